mul_share_arbiter: RTL

- Shares one combinational fixed-point `multiplier` instance among N_REQ requesters.
- Arbitrates with a round-robin policy.
- Holds the winner's operands stable in registers on the multiplier inputs.
- Waits MUL_CYCLES clocks for the multiplier's worst-case delay, then registers the product and returns it with the requester ID over a valid/ready response port.
- Sits between PE-side request logic and the single shared multiplier, so multiplier area is paid once.

---
 rtl/mul_share_arbiter_if.sv | 29 ++
 rtl/mul_share_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between the PE-side requesters and the shared multiplier arbiter.
// Operands are packed per requester: requester i sits at [i*WIDTH +: WIDTH].
interface mul_share_arbiter_if #(
    parameter int N_REQ     = 4,
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int OUT_WIDTH = 32
);
    localparam int ID_WIDTH = $clog2(N_REQ);

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*A_WIDTH-1:0] req_a;
    logic [N_REQ*B_WIDTH-1:0] req_b;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_WIDTH-1:0]      rsp_id;
    logic [OUT_WIDTH-1:0]     rsp_data;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one combinational multiplier between N_REQ requesters,
// holding the winner's operands steady for MUL_CYCLES clocks before capturing the product.
//
// state | meaning
// IDLE  | searching for a requester; req_ready asserted toward the round-robin winner
// WAIT  | operands held on the multiplier inputs while it settles (cnt counts down)
// RESP  | product registered; rsp_valid held until the consumer takes it
module mul_share_arbiter #(
    parameter int N_REQ      = 4,
    parameter int A_WIDTH    = 16,
    parameter int B_WIDTH    = 16,
    parameter int OUT_WIDTH  = 32,
    parameter int MUL_CYCLES = 1,
    localparam int ID_WIDTH  = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 arst_n_in,
    mul_share_arbiter_if.slave   bus,
    output logic [A_WIDTH-1:0]   mul_a,
    output logic [B_WIDTH-1:0]   mul_b,
    input  logic [OUT_WIDTH-1:0] mul_out,
    output logic                 busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state_q;
    state_t              state_d;
    logic [ID_WIDTH-1:0] last_grant;
    logic [ID_WIDTH-1:0] grant_idx;
    logic                grant_found;
    logic [3:0]          cnt;
    logic                accept;
    logic                capture;
    logic                rsp_hs;

    // First valid requester after last_grant, wrapping around.
    always_comb begin : rr_search
        int idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_grant) + k) % N_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_WIDTH'(idx);
            end
        end
    end

    assign accept  = (state_q == IDLE) && grant_found && arst_n_in;
    assign capture = (state_q == WAIT) && (cnt == 4'd1);
    assign rsp_hs  = (state_q == RESP) && bus.rsp_ready;
    assign busy    = (state_q != IDLE);

    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = WAIT;
            WAIT:    if (cnt == 4'd1) state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n_in) begin
            state_q       <= IDLE;
            last_grant    <= ID_WIDTH'(N_REQ - 1);
            cnt           <= '0;
            mul_a         <= '0;
            mul_b         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            state_q <= state_d;
            // Operands only move on an accept so the multiplier sees one clean transition.
            if (accept) begin
                mul_a      <= bus.req_a[grant_idx*A_WIDTH +: A_WIDTH];
                mul_b      <= bus.req_b[grant_idx*B_WIDTH +: B_WIDTH];
                bus.rsp_id <= grant_idx;
                last_grant <= grant_idx;
                cnt        <= 4'(MUL_CYCLES);
            end else if (state_q == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (capture) begin
                bus.rsp_data  <= mul_out;
                bus.rsp_valid <= 1'b1;
            end else if (rsp_hs) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end
endmodule
